cistercian_scan_driver: RTL and testbench

Time-multiplexed driver for a row of Cistercian-numeral digit positions. It latches CHANNELS 4-bit codes and scans one shared 5-line stroke bus (U..Y) across a one-hot digit-select bus. Display updates are tear-free: new data is applied only at frame boundaries. It sits between the numeric datapath and the display, and generalises the fixed dual combinational decoder to N scanned channels.

---
 rtl/cistercian_scan_driver.sv | 136 +++++++++++++
 tb/tb_cistercian_scan_driver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cistercian_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : cistercian_scan_driver
// Purpose  : Time-multiplexed Cistercian-numeral driver; scans CHANNELS digit
//            positions over one shared 5-line stroke bus with tear-free updates.
// Options  : CISTERCIAN_DEADTIME_EN -- one blank cycle at the start of each slot
// Revision : 1.0  initial release
// ============================================================================
module cistercian_scan_driver #(
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*CHANNELS-1:0] data_i,
  input  logic                  le_i,
  input  logic [CHANNELS-1:0]   lt_i,
  input  logic                  bi_i,
  input  logic                  al_i,
  output logic                  u_o,
  output logic                  v_o,
  output logic                  w_o,
  output logic                  x_o,
  output logic                  y_o,
  output logic [CHANNELS-1:0]   dig_o,
  output logic                  frame_o
);

  localparam int              SW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [SW-1:0]   SLOT_LAST = SW'(CHANNELS - 1);
  localparam logic [15:0]     PCNT_LAST = 16'(PRESCALE - 1);

  logic [4*CHANNELS-1:0] pend_q, pend_d;
  logic [4*CHANNELS-1:0] disp_q, disp_d;
  logic [15:0]           pcnt_q, pcnt_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [4:0]            strokes_q, strokes_d;
  logic [CHANNELS-1:0]   dig_q, dig_d;
  logic                  frame_q, frame_d;

  logic                  w_tc;
  logic                  w_boundary;
  logic [3:0]            w_sel_code;
  logic                  w_sel_lt;
  logic [4:0]            w_out_strokes;

  // Stroke bits are ordered {U,V,W,X,Y}.
  function automatic logic [4:0] stroke_code(input logic [3:0] v);
    case (v)
      4'd0:    stroke_code = 5'b00000;
      4'd1:    stroke_code = 5'b10000;
      4'd2:    stroke_code = 5'b01000;
      4'd3:    stroke_code = 5'b00100;
      4'd4:    stroke_code = 5'b00010;
      4'd5:    stroke_code = 5'b10010;
      4'd6:    stroke_code = 5'b00001;
      4'd7:    stroke_code = 5'b10001;
      4'd8:    stroke_code = 5'b01001;
      4'd9:    stroke_code = 5'b11001;
      4'd10:   stroke_code = 5'b11110;
      4'd11:   stroke_code = 5'b10011;
      4'd12:   stroke_code = 5'b11101;
      4'd13:   stroke_code = 5'b11011;
      4'd14:   stroke_code = 5'b10111;
      default: stroke_code = 5'b01111;
    endcase
  endfunction

  assign w_tc       = (pcnt_q == PCNT_LAST);
  assign w_boundary = w_tc && (slot_q == SLOT_LAST);

  always_comb begin
    pend_d  = le_i ? data_i : pend_q;
    disp_d  = disp_q;
    pcnt_d  = pcnt_q + 16'd1;
    slot_d  = slot_q;
    frame_d = w_boundary;

    if (w_tc) begin
      pcnt_d = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
    end
    // Tear-free update: the displayed set only changes on a frame wrap.
    if (w_boundary) begin
      disp_d = le_i ? data_i : pend_q;
    end
  end

  always_comb begin
    w_sel_code = '0;
    w_sel_lt   = 1'b1;
    dig_d      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (slot_d == SW'(k)) begin
        w_sel_code = disp_d[4*k +: 4];
        w_sel_lt   = lt_i[k];
        dig_d[k]   = 1'b1;
      end
    end
    strokes_d = w_sel_lt ? stroke_code(w_sel_code) : 5'b11111;
`ifdef CISTERCIAN_DEADTIME_EN
    if (pcnt_d == 16'd0) begin
      dig_d     = '0;
      strokes_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      disp_q    <= '0;
      pcnt_q    <= '0;
      slot_q    <= '0;
      strokes_q <= '0;
      dig_q     <= '0;
      frame_q   <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      disp_q    <= disp_d;
      pcnt_q    <= pcnt_d;
      slot_q    <= slot_d;
      strokes_q <= strokes_d;
      dig_q     <= dig_d;
      frame_q   <= frame_d;
    end
  end

  // Blanking and polarity are combinational so they act in the same cycle.
  assign w_out_strokes = (strokes_q & {5{bi_i}}) ^ {5{~al_i}};
  assign {u_o, v_o, w_o, x_o, y_o} = w_out_strokes;
  assign dig_o   = (dig_q & {CHANNELS{bi_i}}) ^ {CHANNELS{~al_i}};
  assign frame_o = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_cistercian_scan_driver.sv
`default_nettype none
// Testbench for cistercian_scan_driver (CHANNELS=4, PRESCALE=4): directed and
// random stimulus checked cycle by cycle against a frame-arithmetic model.
module tb_cistercian_scan_driver;

  localparam int CH  = 4;
  localparam int P   = 4;
  localparam int FRM = CH * P;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*CH-1:0] data;
  logic          le;
  logic [CH-1:0] lt;
  logic          bi;
  logic          al;
  logic          u, v, w, x, y;
  logic [CH-1:0] dig;
  logic          frame;

  int tests  = 0;
  int failed = 0;

  // Model state: edges since reset release, latest captured and displayed data.
  int            t;
  logic [15:0]   m_pend, m_disp;
  logic [4:0]    m_str;
  logic [CH-1:0] m_dig;
  logic          m_frame;

  logic [4:0] CODE [16] = '{5'b00000, 5'b10000, 5'b01000, 5'b00100,
                            5'b00010, 5'b10010, 5'b00001, 5'b10001,
                            5'b01001, 5'b11001, 5'b11110, 5'b10011,
                            5'b11101, 5'b11011, 5'b10111, 5'b01111};

  cistercian_scan_driver #(.CHANNELS(CH), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data), .le_i(le), .lt_i(lt),
    .bi_i(bi), .al_i(al), .u_o(u), .v_o(v), .w_o(w), .x_o(x), .y_o(y),
    .dig_o(dig), .frame_o(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("strokes", 32'({u, v, w, x, y}), 32'((m_str & {5{bi}}) ^ {5{~al}}));
    chk("dig", 32'(dig), 32'((m_dig & {CH{bi}}) ^ {CH{~al}}));
    chk("frame", 32'(frame), 32'(m_frame));
  endtask

  task automatic model_reset();
    t = 0; m_pend = '0; m_disp = '0; m_str = '0; m_dig = '0; m_frame = 1'b0;
  endtask

  // One clock: advance the model from the inputs present at the edge, then check.
  task automatic tick();
    int s;
    @(posedge clk);
    if (rst_n) begin
      t++;
      m_frame = (t % FRM) == 0;
      if (m_frame) m_disp = le ? data : m_pend;
      if (le) m_pend = data;
      s = (t / P) % CH;
      m_dig = CH'(1) << s;
      m_str = lt[s] ? CODE[m_disp[4*s +: 4]] : 5'b11111;
`ifdef CISTERCIAN_DEADTIME_EN
      if (t % P == 0) begin
        m_dig = '0;
        m_str = '0;
      end
`endif
    end
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; le = 1'b0; data = '0; lt = '1; bi = 1'b1; al = 1'b1;
    model_reset();
    repeat (3) tick();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic scan with 3210 captured by one LE pulse.
    repeat (3) tick();
    data = 16'h3210; le = 1'b1;
    tick();
    le = 1'b0; data = 16'h0000;
    repeat (3 * FRM) tick();

    // Every code value through channel 0.
    for (int c = 0; c < 16; c++) begin
      data = {12'($urandom), 4'(c)}; le = 1'b1;
      tick();
      le = 1'b0;
      repeat (2 * FRM) tick();
    end

    // Mid-frame load held off until the wrap.
    while ((t % FRM) != 5) tick();
    data = 16'hFFFF; le = 1'b1;
    tick();
    le = 1'b0; data = 16'($urandom);
    repeat (FRM + 4) tick();

    // Load on the boundary cycle goes straight to the display.
    while (((t + 1) % FRM) != 0) tick();
    data = 16'h5A3C; le = 1'b1;
    tick();
    le = 1'b0;
    repeat (FRM) tick();

    // Lamp test on channel 2 only.
    lt = 4'b1011;
    repeat (FRM + 1) tick();
    lt = '1;
    tick();

    // Blanking and polarity act without a clock edge.
    bi = 1'b0; #1; check_all();
    chk("blank_raw", 32'({u, v, w, x, y, dig}), 32'd0);
    bi = 1'b1; al = 1'b0; #1; check_all();
    repeat (FRM) tick();
    al = 1'b1;

    // Random traffic on every input.
    repeat (400) begin
      data = 16'($urandom);
      le   = ($urandom_range(0, 7) == 0);
      lt   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
      bi   = ($urandom_range(0, 9) != 0);
      al   = ($urandom_range(0, 9) != 0);
      tick();
    end
    le = 1'b0; lt = '1; bi = 1'b1; al = 1'b1;

    // Asynchronous reset inside channel 2's slot.
    while (((t / P) % CH) != 2 || (t % P) != 1) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("reset_dig_inactive", 32'(dig), 32'h0);
    repeat (2) tick();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2 * FRM) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
